usr_counter_ext: RTL and testbench

- Parametrised successor to the free-running user counter.
- Counts up or down at a programmable rate set by an integrated prescaler.
- Has a run-time limit, three terminal modes (wrap, saturate, one-shot), parallel load and start/stop control.
- Sits in the user logic region on usr_clk; drives interval timers, frame counters and debug LEDs.

---
 rtl/usr_counter_pkg.sv | 23 ++
 rtl/usr_prescaler.sv | 40 ++++
 rtl/usr_counter_ext.sv | 120 ++++++++++++
 tb/tb_usr_counter_ext.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/usr_counter_pkg.sv
// +--------------------------------------------------------------------+
// | usr_counter_pkg: mode, direction and state encodings, revision 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

package usr_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'd0;
  localparam logic [1:0] MODE_SAT     = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/usr_prescaler.sv
// +--------------------------------------------------------------------+
// | usr_prescaler: step pulse every cmp+1 enabled cycles, revision 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

module usr_prescaler
  import usr_counter_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] cmp,
  output logic                  step
);

  logic [PRESCALE_W-1:0] cnt;

  // A lowered cmp lets cnt run past it and wrap through zero naturally.
  assign step = en && !clr && (cnt == cmp);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == cmp) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/usr_counter_ext.sv
// +--------------------------------------------------------------------+
// | usr_counter_ext: up/down prescaled counter with limit, wrap,        |
// | saturate and one-shot terminal modes, revision 1.0                 |
// +--------------------------------------------------------------------+
`default_nettype none

module usr_counter_ext
  import usr_counter_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  usr_clk,
  input  logic                  usr_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic [WIDTH-1:0]      i_load_val,
  input  logic                  i_dir,
  input  logic [1:0]            i_mode,
  input  logic [WIDTH-1:0]      i_limit,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_tick,
  output logic                  o_tc,
  output logic                  o_busy,
  output logic                  o_done
);

  state_t           state;
  state_t           state_nx;
  logic             step;
  logic             presc_en;
  logic             presc_clr;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] term_val;
  logic             at_term;
  logic             advance;
  logic             landed;

  // Stop outranks the step, so the prescaler freezes in that cycle too.
  assign presc_en  = (state == ST_RUN) && i_en && !i_stop;
  assign presc_clr = i_load || i_start;

  usr_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk  (usr_clk),
    .rst  (usr_rst),
    .clr  (presc_clr),
    .en   (presc_en),
    .cmp  (i_prescale),
    .step (step)
  );

  always_comb begin
    step_val = o_count;
    advance  = 1'b0;
    term_val = (i_dir == DIR_DOWN) ? '0 : i_limit;
    at_term  = (i_dir == DIR_DOWN) ? (o_count == '0) : (o_count >= i_limit);
    if (!at_term) begin
      step_val = (i_dir == DIR_DOWN) ? (o_count - 1'b1) : (o_count + 1'b1);
      advance  = 1'b1;
    end else if (i_mode == MODE_SAT) begin
      // Saturation pins an over-limit up count to the limit without a tick.
      step_val = (i_dir == DIR_DOWN) ? o_count : i_limit;
      advance  = 1'b0;
    end else begin
      step_val = (i_dir == DIR_DOWN) ? i_limit : '0;
      advance  = 1'b1;
    end
    landed = advance && (step_val == term_val);
  end

  always_comb begin
    state_nx = state;
    if (i_load) begin
      if (state == ST_DONE) begin
        state_nx = ST_IDLE;
      end
    end else if (i_stop) begin
      state_nx = ST_IDLE;
    end else if (i_start) begin
      state_nx = ST_RUN;
    end else if (step && landed && (i_mode == MODE_ONESHOT)) begin
      state_nx = ST_DONE;
    end
  end

  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      o_count <= '0;
      o_tick  <= 1'b0;
      o_tc    <= 1'b0;
    end else begin
      o_tick <= step && advance;
      o_tc   <= step && landed;
      if (i_load) begin
        o_count <= i_load_val;
      end else if (step) begin
        o_count <= step_val;
      end
    end
  end

  assign o_busy = (state == ST_RUN);
  assign o_done = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_usr_counter_ext.sv
// +--------------------------------------------------------------------+
// | tb_usr_counter_ext: directed plan plus random run vs. a reference  |
// | model, revision 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_usr_counter_ext;

  localparam int WIDTH = 4;
  localparam int PW    = 3;
  localparam int CMOD  = 1 << WIDTH;
  localparam int PMOD  = 1 << PW;

  logic             usr_clk = 1'b0;
  logic             usr_rst;
  logic             i_start, i_stop, i_en, i_load, i_dir;
  logic [WIDTH-1:0] i_load_val, i_limit;
  logic [1:0]       i_mode;
  logic [PW-1:0]    i_prescale;
  logic [WIDTH-1:0] o_count;
  logic             o_tick, o_tc, o_busy, o_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: state 0 = idle, 1 = run, 2 = done.
  int m_count = 0, m_presc = 0, m_state = 0, m_tick = 0, m_tc = 0;

  usr_counter_ext #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .usr_clk(usr_clk), .usr_rst(usr_rst), .i_start(i_start), .i_stop(i_stop),
    .i_en(i_en), .i_load(i_load), .i_load_val(i_load_val), .i_dir(i_dir),
    .i_mode(i_mode), .i_limit(i_limit), .i_prescale(i_prescale),
    .o_count(o_count), .o_tick(o_tick), .o_tc(o_tc), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 usr_clk = ~usr_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int lim, nv, term, adv;
    lim = int'(i_limit);
    if (i_dir == 1'b0) begin
      term = lim;
      if (m_count < lim)        begin nv = (m_count + 1) % CMOD; adv = 1; end
      else if (i_mode == 2'd1)  begin nv = lim;                  adv = 0; end
      else                      begin nv = 0;                    adv = 1; end
    end else begin
      term = 0;
      if (m_count > 0)          begin nv = m_count - 1;          adv = 1; end
      else if (i_mode == 2'd1)  begin nv = 0;                    adv = 0; end
      else                      begin nv = lim;                  adv = 1; end
    end
    m_count = nv;
    m_tick  = adv;
    m_tc    = (adv == 1 && nv == term) ? 1 : 0;
    if (m_tc == 1 && i_mode == 2'd2) m_state = 2;
  endtask

  task automatic model_clock();
    if (usr_rst) begin
      m_count = 0; m_presc = 0; m_state = 0; m_tick = 0; m_tc = 0;
      return;
    end
    m_tick = 0;
    m_tc   = 0;
    if (i_load) begin
      m_count = int'(i_load_val);
      m_presc = 0;
      if (m_state == 2) m_state = 0;
    end else if (i_stop) begin
      m_state = 0;
    end else if (i_start) begin
      m_presc = 0;
      m_state = 1;
    end else if (m_state == 1 && i_en) begin
      if (m_presc == int'(i_prescale)) begin
        m_presc = 0;
        model_step();
      end else begin
        m_presc = (m_presc + 1) % PMOD;
      end
    end
  endtask

  task automatic cyc();
    model_clock();
    @(posedge usr_clk);
    #1;
    check("count", 32'(o_count), m_count);
    check("tick",  32'(o_tick),  m_tick);
    check("tc",    32'(o_tc),    m_tc);
    check("busy",  32'(o_busy),  (m_state == 1) ? 1 : 0);
    check("done",  32'(o_done),  (m_state == 2) ? 1 : 0);
    i_load  = 1'b0;
    i_start = 1'b0;
    i_stop  = 1'b0;
  endtask

  task automatic load_start(input int val);
    i_stop = 1'b1;
    cyc();
    i_load = 1'b1;
    i_load_val = WIDTH'(val);
    cyc();
    i_start = 1'b1;
    cyc();
  endtask

  initial begin
    int ticks, tcs;
    usr_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_en = 1'b1; i_load = 1'b0;
    i_load_val = '0; i_dir = 1'b0; i_mode = 2'd0; i_limit = 4'd9; i_prescale = '0;
    cyc();
    cyc();
    check("rst_count", 32'(o_count), 0);
    usr_rst = 1'b0;

    // Plan 1: up/wrap to 9 at full rate.
    i_start = 1'b1;
    cyc();
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check("t1_seq", 32'(o_count), k % 10);
      check("t1_tc", 32'(o_tc), (k == 9) ? 1 : 0);
    end
    check("t1_busy", 32'(o_busy), 1);

    // Plan 2: prescale 3, en dropped for 5 cycles.
    i_prescale = 3'd3; i_limit = 4'd15;
    load_start(0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check("t2_tick", 32'(o_tick), (k % 4 == 0) ? 1 : 0);
    end
    i_en = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    i_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("t2_tick_gap", 32'(o_tick), (k == 4) ? 1 : 0);
    end

    // Plan 3: saturate down from 3.
    i_prescale = '0; i_mode = 2'd1; i_dir = 1'b1;
    load_start(3);
    ticks = 0; tcs = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      ticks += int'(o_tick);
      tcs   += int'(o_tc);
    end
    check("t3_count", 32'(o_count), 0);
    check("t3_ticks", ticks, 3);
    check("t3_tcs", tcs, 1);

    // Plan 4: one-shot up to 5, then restart to 7.
    i_mode = 2'd2; i_dir = 1'b0; i_limit = 4'd5;
    load_start(2);
    for (int k = 0; k < 5; k++) cyc();
    check("t4_count", 32'(o_count), 5);
    check("t4_done", 32'(o_done), 1);
    check("t4_busy", 32'(o_busy), 0);
    i_limit = 4'd7; i_start = 1'b1;
    cyc();
    cyc();
    check("t4_c6", 32'(o_count), 6);
    cyc();
    check("t4_c7", 32'(o_count), 7);
    check("t4_done2", 32'(o_done), 1);

    // Plan 5: load beats stop and a due step.
    i_mode = 2'd0; i_limit = 4'd15;
    load_start(0);
    cyc();
    cyc();
    i_load = 1'b1; i_load_val = 4'd8; i_stop = 1'b1;
    cyc();
    check("t5_count", 32'(o_count), 8);
    check("t5_busy", 32'(o_busy), 1);
    check("t5_tick", 32'(o_tick), 0);

    // Plan 6: reset mid-run at 6.
    i_load = 1'b1; i_load_val = 4'd5;
    cyc();
    cyc();
    check("t6_pre", 32'(o_count), 6);
    usr_rst = 1'b1;
    cyc();
    check("t6_rst_count", 32'(o_count), 0);
    check("t6_rst_busy", 32'(o_busy), 0);
    usr_rst = 1'b0; i_start = 1'b1;
    cyc();
    cyc();
    check("t6_from0", 32'(o_count), 1);

    // Random run against the model.
    for (int k = 0; k < 3000; k++) begin
      usr_rst = ($urandom_range(0, 299) == 0);
      i_load  = ($urandom_range(0, 15) == 0);
      i_stop  = ($urandom_range(0, 31) == 0);
      i_start = ($urandom_range(0, 7) == 0);
      i_en    = ($urandom_range(0, 4) != 0);
      i_load_val = WIDTH'($urandom_range(0, CMOD - 1));
      if ($urandom_range(0, 29) == 0) i_dir = ~i_dir;
      if ($urandom_range(0, 29) == 0) i_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) i_limit = WIDTH'($urandom_range(0, CMOD - 1));
      if ($urandom_range(0, 24) == 0) i_prescale = PW'($urandom_range(0, PMOD - 1));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
